// File: rtl/manchester_bit_decoder.sv
// Manchester bit decoder.
// Pairs half-bit samples taken on recovered-clock edges into bits, hunts for
// the sync word, then assembles MSB-first bytes into a one-entry valid/ready
// output buffer. Reports code violations inside a frame, dropped bytes, and
// ends a frame when the half-bit ticks stop for IDLE_TIMEOUT cycles.
module manchester_bit_decoder #(
  parameter logic [7:0] SYNC_WORD     = 8'hD5,
  parameter int         IDLE_TIMEOUT  = 64,
  parameter int         TIMEOUT_WIDTH = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       digital_in,
  input  logic       manchester_clock,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_active,
  output logic       code_error,
  output logic       overrun
);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  // The timeout fires on the cycle the counter steps from IDLE_TIMEOUT-1 to
  // IDLE_TIMEOUT; the counter then parks at IDLE_TIMEOUT so it fires once.
  localparam logic [TIMEOUT_WIDTH-1:0] IDLE_LAST = TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] IDLE_MAX  = TIMEOUT_WIDTH'(IDLE_TIMEOUT);
  localparam logic [TIMEOUT_WIDTH-1:0] IDLE_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  // State registers
  state_t                   state_r;
  logic                     mclk_d_r;
  logic                     half_sel_r;
  logic                     first_half_r;
  logic [7:0]               sync_r;
  logic [7:0]               byte_r;
  logic [2:0]               bit_cnt_r;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_r;
  logic [7:0]               data_out_r;
  logic                     data_valid_r;
  logic                     frame_active_r;
  logic                     code_error_r;
  logic                     overrun_r;

  // Next-state values
  state_t                   state_nxt_s;
  logic                     half_sel_nxt_s;
  logic                     first_half_nxt_s;
  logic [7:0]               sync_nxt_s;
  logic [7:0]               byte_nxt_s;
  logic [2:0]               bit_cnt_nxt_s;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_nxt_s;
  logic [7:0]               data_out_nxt_s;
  logic                     data_valid_nxt_s;
  logic                     code_error_nxt_s;
  logic                     overrun_nxt_s;

  // Decode helpers
  logic       tick_s;
  logic       pair_s;
  logic       violation_s;
  logic       bit_ok_s;
  logic       timeout_s;
  logic       byte_done_s;
  logic       load_s;
  logic [7:0] shifted_sync_s;
  logic [7:0] shifted_byte_s;

  // A pair (0,1) decodes to 1 and (1,0) to 0, so a valid bit equals the
  // second half sample; equal halves are a violation.
  assign tick_s         = manchester_clock ^ mclk_d_r;
  assign pair_s         = tick_s & half_sel_r;
  assign violation_s    = pair_s & (first_half_r == digital_in);
  assign bit_ok_s       = pair_s & (first_half_r != digital_in);
  assign timeout_s      = ~tick_s & (idle_cnt_r == IDLE_LAST);
  assign shifted_sync_s = {sync_r[6:0], digital_in};
  assign shifted_byte_s = {byte_r[6:0], digital_in};

  // Frame FSM next state: half pairing, sync hunt and byte assembly
  always_comb begin
    state_nxt_s      = state_r;
    half_sel_nxt_s   = half_sel_r;
    first_half_nxt_s = first_half_r;
    sync_nxt_s       = sync_r;
    byte_nxt_s       = byte_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    byte_done_s      = 1'b0;
    code_error_nxt_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (tick_s && !half_sel_r) begin
          first_half_nxt_s = digital_in;
          half_sel_nxt_s   = 1'b1;
        end else if (violation_s) begin
          // Realign: the second sample becomes the first half of the next pair.
          first_half_nxt_s = digital_in;
          half_sel_nxt_s   = 1'b1;
        end else if (bit_ok_s) begin
          half_sel_nxt_s = 1'b0;
          sync_nxt_s     = shifted_sync_s;
          if (shifted_sync_s == SYNC_WORD) begin
            state_nxt_s   = RECEIVE;
            bit_cnt_nxt_s = 3'd0;
            byte_nxt_s    = 8'h00;
          end else begin
            state_nxt_s = HUNT;
          end
        end else if (timeout_s) begin
          half_sel_nxt_s = 1'b0;
          sync_nxt_s     = 8'h00;
        end else begin
          state_nxt_s = HUNT;
        end
      end
      RECEIVE: begin
        if (tick_s && !half_sel_r) begin
          first_half_nxt_s = digital_in;
          half_sel_nxt_s   = 1'b1;
        end else if (violation_s) begin
          code_error_nxt_s = 1'b1;
          state_nxt_s      = HUNT;
          half_sel_nxt_s   = 1'b0;
          sync_nxt_s       = 8'h00;
          bit_cnt_nxt_s    = 3'd0;
          byte_nxt_s       = 8'h00;
        end else if (bit_ok_s) begin
          half_sel_nxt_s = 1'b0;
          byte_nxt_s     = shifted_byte_s;
          if (bit_cnt_r == 3'd7) begin
            byte_done_s   = 1'b1;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end else if (timeout_s) begin
          state_nxt_s    = HUNT;
          half_sel_nxt_s = 1'b0;
          sync_nxt_s     = 8'h00;
          bit_cnt_nxt_s  = 3'd0;
          byte_nxt_s     = 8'h00;
        end else begin
          state_nxt_s = RECEIVE;
        end
      end
      default: begin
        state_nxt_s    = HUNT;
        half_sel_nxt_s = 1'b0;
        sync_nxt_s     = 8'h00;
        bit_cnt_nxt_s  = 3'd0;
        byte_nxt_s     = 8'h00;
      end
    endcase
  end

  // Idle counter: cleared by every tick, otherwise counts up and saturates
  always_comb begin
    idle_cnt_nxt_s = idle_cnt_r;
    if (tick_s) begin
      idle_cnt_nxt_s = {TIMEOUT_WIDTH{1'b0}};
    end else if (idle_cnt_r != IDLE_MAX) begin
      idle_cnt_nxt_s = idle_cnt_r + IDLE_ONE;
    end else begin
      idle_cnt_nxt_s = idle_cnt_r;
    end
  end

  // Output buffer: load when empty or being drained this cycle, else drop
  always_comb begin
    data_out_nxt_s   = data_out_r;
    data_valid_nxt_s = data_valid_r;
    load_s           = byte_done_s & (~data_valid_r | data_ready);
    overrun_nxt_s    = byte_done_s & ~load_s;
    if (load_s) begin
      data_out_nxt_s   = shifted_byte_s;
      data_valid_nxt_s = 1'b1;
    end else if (data_valid_r && data_ready) begin
      data_valid_nxt_s = 1'b0;
    end else begin
      data_valid_nxt_s = data_valid_r;
    end
  end

  // Register all state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= HUNT;
      mclk_d_r       <= 1'b0;
      half_sel_r     <= 1'b0;
      first_half_r   <= 1'b0;
      sync_r         <= 8'h00;
      byte_r         <= 8'h00;
      bit_cnt_r      <= 3'd0;
      idle_cnt_r     <= {TIMEOUT_WIDTH{1'b0}};
      data_out_r     <= 8'h00;
      data_valid_r   <= 1'b0;
      frame_active_r <= 1'b0;
      code_error_r   <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      mclk_d_r       <= manchester_clock;
      half_sel_r     <= half_sel_nxt_s;
      first_half_r   <= first_half_nxt_s;
      sync_r         <= sync_nxt_s;
      byte_r         <= byte_nxt_s;
      bit_cnt_r      <= bit_cnt_nxt_s;
      idle_cnt_r     <= idle_cnt_nxt_s;
      data_out_r     <= data_out_nxt_s;
      data_valid_r   <= data_valid_nxt_s;
      frame_active_r <= (state_nxt_s == RECEIVE);
      code_error_r   <= code_error_nxt_s;
      overrun_r      <= overrun_nxt_s;
    end
  end

  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign frame_active = frame_active_r;
  assign code_error   = code_error_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_manchester_bit_decoder.sv
// Directed testbench for manchester_bit_decoder.
// Half-bit ticks are produced by toggling manchester_clock every 10 cycles;
// outputs are checked 1 time unit after the rising edge.
module tb_manchester_bit_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       digital_in = 1'b0;
  logic       manchester_clock = 1'b0;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_active;
  logic       code_error;
  logic       overrun;

  int         vectors = 0;
  int         miscompares = 0;
  int         ce_cnt = 0;
  int         ov_cnt = 0;
  int         acc_cnt = 0;
  logic [7:0] last_acc = 8'h00;
  int         ce_base;
  int         ov_base;
  int         acc_base;

  manchester_bit_decoder #(
    .SYNC_WORD    (8'hD5),
    .IDLE_TIMEOUT (64),
    .TIMEOUT_WIDTH(7)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .digital_in      (digital_in),
    .manchester_clock(manchester_clock),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .frame_active    (frame_active),
    .code_error      (code_error),
    .overrun         (overrun)
  );

  always #5 clock = ~clock;

  // Event log taken mid-cycle: error/overrun pulses and accepted bytes
  always @(negedge clock) begin
    if (!reset) begin
      if (code_error) ce_cnt++;
      if (overrun) ov_cnt++;
      if (data_valid && data_ready) begin
        acc_cnt++;
        last_acc = data_out;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // One half sample: toggle the recovered clock, the tick is sampled at the next edge
  task automatic half_tick(input logic b);
    digital_in       = b;
    manchester_clock = ~manchester_clock;
    step();
  endtask

  task automatic send_half(input logic b);
    half_tick(b);
    idle(9);
  endtask

  // Bit 1 is (0,1), bit 0 is (1,0)
  task automatic send_bit(input logic b);
    send_half(~b);
    send_half(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Everything except the final half sample of the byte
  task automatic send_byte_but_last(input logic [7:0] v);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    send_half(~v[0]);
  endtask

  initial begin
    // 1: reset held while the recovered clock toggles
    for (int i = 0; i < 5; i++) begin
      manchester_clock = ~manchester_clock;
      step();
      check("rst_valid", {31'd0, data_valid}, 32'd0);
    end
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_frame", {31'd0, frame_active}, 32'd0);
    check("rst_cerr", {31'd0, code_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    manchester_clock = 1'b0;
    reset = 1'b0;
    step();

    // 2: preamble, sync, one byte with consumer ready
    data_ready = 1'b1;
    send_byte(8'h55);
    send_byte_but_last(8'hD5);
    check("t2_frame_pre", {31'd0, frame_active}, 32'd0);
    half_tick(1'b1);
    check("t2_frame_rise", {31'd0, frame_active}, 32'd1);
    idle(9);
    send_byte_but_last(8'hA3);
    check("t2_valid_pre", {31'd0, data_valid}, 32'd0);
    half_tick(1'b1);
    check("t2_valid", {31'd0, data_valid}, 32'd1);
    check("t2_data", {24'd0, data_out}, 32'hA3);
    step();
    check("t2_valid_fall", {31'd0, data_valid}, 32'd0);
    check("t2_acc_cnt", acc_cnt, 32'd1);
    check("t2_acc_byte", {24'd0, last_acc}, 32'hA3);
    check("t2_cerr_cnt", ce_cnt, 32'd0);
    check("t2_ovr_cnt", ov_cnt, 32'd0);
    idle(70);
    check("t2_timeout", {31'd0, frame_active}, 32'd0);

    // 3: one stray half sample before the preamble forces realignment
    ce_base  = ce_cnt;
    acc_base = acc_cnt;
    send_half(1'b1);
    send_byte(8'h55);
    send_byte(8'hD5);
    send_byte(8'hA3);
    idle(3);
    check("t3_acc_cnt", acc_cnt, acc_base + 1);
    check("t3_acc_byte", {24'd0, last_acc}, 32'hA3);
    check("t3_cerr_cnt", ce_cnt, ce_base);
    idle(70);

    // 4: consumer stalled, second byte overruns
    data_ready = 1'b0;
    ov_base  = ov_cnt;
    acc_base = acc_cnt;
    send_byte(8'hD5);
    send_byte_but_last(8'h12);
    half_tick(1'b0);
    check("t4_valid", {31'd0, data_valid}, 32'd1);
    check("t4_data", {24'd0, data_out}, 32'h12);
    check("t4_ovr_early", {31'd0, overrun}, 32'd0);
    idle(9);
    send_byte_but_last(8'h34);
    half_tick(1'b0);
    check("t4_ovr_pulse", {31'd0, overrun}, 32'd1);
    check("t4_data_held", {24'd0, data_out}, 32'h12);
    check("t4_valid_held", {31'd0, data_valid}, 32'd1);
    step();
    check("t4_ovr_end", {31'd0, overrun}, 32'd0);
    check("t4_ovr_cnt", ov_cnt, ov_base + 1);
    data_ready = 1'b1;
    step();
    check("t4_valid_fall", {31'd0, data_valid}, 32'd0);
    check("t4_acc_byte", {24'd0, last_acc}, 32'h12);
    check("t4_acc_cnt", acc_cnt, acc_base + 1);
    idle(70);

    // 5: violation at bit 4 drops the frame, then relock
    ce_base  = ce_cnt;
    acc_base = acc_cnt;
    send_byte(8'hD5);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_half(1'b1);
    half_tick(1'b1);
    check("t5_cerr_pulse", {31'd0, code_error}, 32'd1);
    check("t5_frame_drop", {31'd0, frame_active}, 32'd0);
    step();
    check("t5_cerr_end", {31'd0, code_error}, 32'd0);
    idle(8);
    send_byte(8'hD5);
    send_byte(8'h5A);
    idle(3);
    check("t5_acc_cnt", acc_cnt, acc_base + 1);
    check("t5_acc_byte", {24'd0, last_acc}, 32'h5A);
    check("t5_cerr_cnt", ce_cnt, ce_base + 1);
    idle(70);

    // 6: ticks stop three bits into a byte
    ce_base  = ce_cnt;
    acc_base = acc_cnt;
    send_byte(8'hD5);
    check("t6_frame_on", {31'd0, frame_active}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_half(1'b0);
    half_tick(1'b1);
    idle(63);
    check("t6_frame_63", {31'd0, frame_active}, 32'd1);
    step();
    check("t6_frame_64", {31'd0, frame_active}, 32'd0);
    check("t6_acc_cnt", acc_cnt, acc_base);
    check("t6_cerr_cnt", ce_cnt, ce_base);
    check("t6_valid", {31'd0, data_valid}, 32'd0);

    // 7: reset mid-frame loses the buffered byte
    data_ready = 1'b0;
    send_byte(8'hD5);
    send_byte(8'h77);
    check("t7_valid", {31'd0, data_valid}, 32'd1);
    check("t7_data", {24'd0, data_out}, 32'h77);
    reset = 1'b1;
    step();
    check("t7_rst_valid", {31'd0, data_valid}, 32'd0);
    check("t7_rst_data", {24'd0, data_out}, 32'd0);
    check("t7_rst_frame", {31'd0, frame_active}, 32'd0);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/manchester_bit_decoder.md
Name: manchester_bit_decoder

Overview:
Downstream stage of the Manchester clock recovery. Consumes the recovered half-bit clock level `manchester_clock` and the synchronised line level `digital_in`. It pairs half-bit samples into decoded bits, hunts for a sync word, then assembles MSB-first bytes. Bytes are delivered through a one-entry valid/ready output buffer, with code-violation, overrun and idle-timeout handling.

Parameters:
SYNC_WORD, 8'hD5, byte pattern that starts a frame (compared after each decoded bit in HUNT)
IDLE_TIMEOUT, 64, clock cycles without a half-bit tick that end a frame
TIMEOUT_WIDTH, 7, width of the idle counter; must satisfy 2**TIMEOUT_WIDTH > IDLE_TIMEOUT

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
digital_in  input  1  synchronised line level
manchester_clock  input  1  recovered clock level; each change marks a half-bit boundary
data_out  output  8  decoded byte, MSB first on the wire
data_valid  output  1  data_out holds an unconsumed byte
data_ready  input  1  consumer accepts data_out when data_valid & data_ready
frame_active  output  1  high while in RECEIVE
code_error  output  1  one-cycle pulse on Manchester violation inside a frame
overrun  output  1  one-cycle pulse when a completed byte is dropped

Behaviour:
- Reset: data_out=0, data_valid=0, frame_active=0, code_error=0, overrun=0. Internally: state=HUNT, half_sel=0, sync shift reg=0, byte reg=0, bit count=0, idle count=0, mclk_d=0.
- Tick detection: mclk_d registers manchester_clock; tick = manchester_clock ^ mclk_d.
- On a tick, digital_in in that same cycle is the half sample.
- Half pairing:
  - half_sel=0: store sample as the first half, set half_sel=1.
  - half_sel=1: evaluate the pair, then clear half_sel.
  - Pair (0,1) = bit 1; (1,0) = bit 0; (0,0) or (1,1) = violation.
- HUNT:
  - Each decoded bit shifts into the sync reg (shift left, new bit at LSB).
  - If the post-shift value == SYNC_WORD: go to RECEIVE next cycle, bit count=0, byte reg=0.
  - Violation in HUNT: the second sample becomes the new first half (half_sel stays 1). This is phase realignment; no error pulse.
- RECEIVE:
  - Each bit shifts into the byte reg, MSB first.
  - On the 8th bit: the byte goes to the output buffer, bit count wraps to 0, and the state stays RECEIVE.
  - Violation: code_error=1 for one cycle, go to HUNT. Partial byte discarded; sync reg, half_sel and bit count cleared.
- Idle counter:
  - Clears on every tick; otherwise increments and saturates.
  - Reaching IDLE_TIMEOUT in RECEIVE: go to HUNT with frame_active=0. Partial byte discarded, no code_error.
  - Reaching IDLE_TIMEOUT in HUNT: half_sel and sync reg cleared.
- Output buffer:
  - A completed byte loads if data_valid=0, or if data_valid & data_ready in the same cycle.
  - Otherwise the byte is dropped and overrun pulses; data_out keeps the old byte.
  - data_out is stable while data_valid=1.
  - data_valid falls after a handshake with no new load.
  - The buffer is independent of state; a byte already buffered survives a code_error or timeout.
- Latency: tick completing a byte at cycle T gives data_valid=1 and data_out at T+1. code_error and overrun assert at T+1. frame_active rises at T+1 after the sync-completing tick.
- Simultaneous events: a tick and a timeout cannot coincide, because a tick clears the counter. A byte completion plus a handshake in the same cycle gives back-to-back valid with no bubble.
- Reset asserted mid-frame: immediate return to reset values on the next edge, buffered byte lost.

Test Plan:
1. Reset held 5 cycles while manchester_clock toggles -> all outputs 0; after release the first toggle is treated as a tick (mclk_d=0).
2. Preamble 0x55, then 0xD5, then 0xA3, ticks every 10 cycles, data_ready=1 -> frame_active=1 one cycle after the last sync tick; data_out=0xA3 with data_valid=1 for exactly 1 cycle; no error pulses.
3. One extra half sample (1) before the preamble of test 2 -> decoder realigns in HUNT; same 0xA3 output, code_error never pulses.
4. After sync, bytes 0x12 then 0x34 with data_ready=0 -> data_out=0x12 held valid; overrun pulses once at 0x34 completion; raising data_ready drops data_valid next cycle, data_out=0x12 consumed.
5. After sync, pair (1,1) at bit 4 of a byte -> code_error pulse, frame_active=0, no byte output. A subsequent 0xD5 then 0x5A -> relocks, outputs 0x5A.
6. After sync and 3 bits, ticks stop -> frame_active falls exactly IDLE_TIMEOUT=64 cycles after the last tick; no data_valid, no code_error.
